// File: rtl/gpio_ctrl.sv
// gpio_ctrl: parametrised GPIO with per-pin direction, atomic set/clear/toggle, 2-flop input sync.
// Optional edge-detect interrupts built when GPIO_CTRL_IRQ_EN is defined.  Revision: 1.0
`default_nettype none

module gpio_ctrl #(
   parameter int                N_PINS    = 16,
   parameter logic [N_PINS-1:0] RESET_OUT = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              write_i,
   input  logic [3:0]        data_be_i,
   input  logic [5:0]        addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   input  logic [N_PINS-1:0] input_i,
   output logic [N_PINS-1:0] output_o,
   output logic [N_PINS-1:0] oe_o,
   output logic              irq_o
);

   localparam logic [3:0] ADDR_DATA_IN    = 4'h0;
   localparam logic [3:0] ADDR_DATA_OUT   = 4'h1;
   localparam logic [3:0] ADDR_DIR        = 4'h2;
   localparam logic [3:0] ADDR_OUT_SET    = 4'h3;
   localparam logic [3:0] ADDR_OUT_CLR    = 4'h4;
   localparam logic [3:0] ADDR_OUT_TGL    = 4'h5;
   localparam logic [3:0] ADDR_IRQ_EN     = 4'h6;
   localparam logic [3:0] ADDR_IRQ_POL    = 4'h7;
   localparam logic [3:0] ADDR_IRQ_STATUS = 4'h8;

   logic [31:0]       be_mask;
   logic [N_PINS-1:0] wmask;
   logic [N_PINS-1:0] wbits;
   logic [3:0]        word;
   logic [N_PINS-1:0] sync1;
   logic [N_PINS-1:0] sync2;
   logic [N_PINS-1:0] data_out;
   logic [N_PINS-1:0] dir;
   logic [N_PINS-1:0] rd_bits;
   logic [31:0]       rd_word;
   logic [31:0]       rdata;
   logic              unused_ok;

   always_comb begin
      be_mask = '0;
      for (int b = 0; b < 4; b++) begin
         be_mask[8*b +: 8] = {8{data_be_i[b]}};
      end
   end

   // Every write operation acts only on enabled lanes within the pin range.
   assign wmask = be_mask[N_PINS-1:0];
   assign wbits = wdata_i[N_PINS-1:0] & wmask;
   assign word  = addr_i[5:2];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= input_i;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_out <= RESET_OUT;
         dir      <= '0;
      end else if (write_i) begin
         case (word)
            ADDR_DATA_OUT: data_out <= (data_out & ~wmask) | wbits;
            ADDR_DIR:      dir      <= (dir & ~wmask) | wbits;
            ADDR_OUT_SET:  data_out <= data_out | wbits;
            ADDR_OUT_CLR:  data_out <= data_out & ~wbits;
            ADDR_OUT_TGL:  data_out <= data_out ^ wbits;
            default:       ;
         endcase
      end
   end

   assign output_o = data_out;
   assign oe_o     = dir;

`ifdef GPIO_CTRL_IRQ_EN
   logic [N_PINS-1:0] irq_en;
   logic [N_PINS-1:0] irq_pol;
   logic [N_PINS-1:0] irq_status;
   logic [N_PINS-1:0] prev;
   logic [N_PINS-1:0] edge_evt;
   logic [N_PINS-1:0] w1c;

   assign edge_evt = (sync2 & ~prev & ~irq_pol) | (~sync2 & prev & irq_pol);
   assign w1c      = (write_i && (word == ADDR_IRQ_STATUS)) ? wbits : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev       <= '0;
         irq_en     <= '0;
         irq_pol    <= '0;
         irq_status <= '0;
      end else begin
         prev       <= sync2;
         // A fresh event outranks a simultaneous clear of the same bit.
         irq_status <= (irq_status & ~w1c) | edge_evt;
         if (write_i) begin
            case (word)
               ADDR_IRQ_EN:  irq_en  <= (irq_en & ~wmask) | wbits;
               ADDR_IRQ_POL: irq_pol <= (irq_pol & ~wmask) | wbits;
               default:      ;
            endcase
         end
      end
   end

   assign irq_o = |(irq_status & irq_en);
`else
   assign irq_o = 1'b0;
`endif

   always_comb begin
      rd_bits = '0;
      case (word)
         ADDR_DATA_IN:    rd_bits = sync2;
         ADDR_DATA_OUT:   rd_bits = data_out;
         ADDR_DIR:        rd_bits = dir;
`ifdef GPIO_CTRL_IRQ_EN
         ADDR_IRQ_EN:     rd_bits = irq_en;
         ADDR_IRQ_POL:    rd_bits = irq_pol;
         ADDR_IRQ_STATUS: rd_bits = irq_status;
`endif
         default:         rd_bits = '0;
      endcase
      rd_word                = '0;
      rd_word[N_PINS-1:0]    = rd_bits;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata <= '0;
      end else if (!write_i) begin
         rdata <= rd_word;
      end
   end

   assign rdata_o   = rdata;
   assign unused_ok = ^{addr_i[1:0], wdata_i, be_mask};

endmodule

`default_nettype wire
